// File: rtl/nibble_add_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nibble_add_pkg
// Brief   : Shared types and constants for the nibble-serial adder.
// Revision: 1.0 - initial release
// ============================================================================
package nibble_add_pkg;

   // Width of the single shared adder slice
   localparam int NIBBLE_W = 4;

   // Controller states; encoding 2'd3 is unused and recovers to IDLE
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : nibble_add_pkg
`default_nettype wire

// File: rtl/nibble_add4.sv
`default_nettype none
// ============================================================================
// Module  : nibble_add4
// Brief   : 4-bit combinational adder with carry-in. Also exposes the carry
//           into bit 3 so the caller can form signed overflow.
// Revision: 1.0 - initial release
// ============================================================================
module nibble_add4
   import nibble_add_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co,
   output logic                c3
);

   logic [3:0] w_lo;   // bits 2..0 plus carry into bit 3
   logic [1:0] w_hi;   // bit 3 plus carry out

   // Split the add at bit 3 so the internal carry is visible
   assign w_lo = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
   assign w_hi = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, w_lo[3]};

   assign s  = {w_hi[0], w_lo[2:0]};
   assign co = w_hi[1];
   assign c3 = w_lo[3];

endmodule : nibble_add4
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : nibble_serial_add_ctrl
// Brief   : Add/subtract of two WIDTH-bit operands using one 4-bit adder,
//           one nibble per clock, LSB nibble first, with valid/ready handshakes
//           on both the operand and the result side.
// Revision: 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl
   import nibble_add_pkg::*;
#(
   parameter int WIDTH = 16   // multiple of 4, at least 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int c_nib   = WIDTH / NIBBLE_W;
   localparam int c_idx_w = (c_nib > 1) ? $clog2(c_nib) : 1;
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nib - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;        // already inverted for subtraction
   logic               r_carry;
   logic [c_idx_w-1:0] r_idx;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               r_ovf;
   logic               r_in_ready;
   logic               r_busy;
   logic               r_out_valid;

   logic [c_idx_w+1:0]  w_base;    // bit offset of the current nibble
   logic [WIDTH-1:0]    w_a_sh;
   logic [WIDTH-1:0]    w_b_sh;
   logic [NIBBLE_W-1:0] w_s;
   logic                w_co;
   logic                w_c3;

   // Nibble k starts at bit 4*k; shifting the latched operands selects it
   assign w_base = {r_idx, 2'b00};
   assign w_a_sh = r_a >> w_base;
   assign w_b_sh = r_b >> w_base;

   nibble_add4 u_add4 (
      .a  (w_a_sh[NIBBLE_W-1:0]),
      .b  (w_b_sh[NIBBLE_W-1:0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co),
      .c3 (w_c3)
   );

   // Controller and datapath: accept, one nibble per cycle, hold result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_carry     <= 1'b0;
         r_idx       <= '0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is a + ~b + 1
                  r_a        <= a;
                  r_b        <= b ^ {WIDTH{sub}};
                  r_carry    <= sub | cin;
                  r_idx      <= '0;
                  r_sum      <= '0;
                  r_cout     <= 1'b0;
                  r_ovf      <= 1'b0;
                  r_state    <= ADD;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            ADD: begin
               for (int k = 0; k < c_nib; k++) begin
                  if (r_idx == c_idx_w'(k)) begin
                     r_sum[k*NIBBLE_W +: NIBBLE_W] <= w_s;
                  end
               end
               r_carry <= w_co;
               if (r_idx == c_last_idx) begin
                  r_idx       <= '0;
                  r_cout      <= w_co;
                  r_ovf       <= w_c3 ^ w_co;
                  r_state     <= DONE;
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_idx       <= '0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign busy      = r_busy;
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule : nibble_serial_add_ctrl
`default_nettype wire
